// File: rtl/xz_input_conditioner_pkg.sv
// Shared encodings for the x/z input conditioner and the controller it feeds.
// Channel debounce states plus the {x,z} pair codes that line up with the
// controller's S0..S3.
package fsm_pkg;

   typedef enum logic {
      DB_IDLE = 1'b0,
      DB_QUAL = 1'b1
   } db_state_e;

   localparam logic [1:0] XZ_00 = 2'b00;
   localparam logic [1:0] XZ_01 = 2'b01;
   localparam logic [1:0] XZ_10 = 2'b10;
   localparam logic [1:0] XZ_11 = 2'b11;

endpackage

// File: rtl/xz_input_conditioner_debounce_chan.sv
// One debounce channel: a SYNC_STAGES-deep synchroniser followed by a
// two-state qualifier. The output only moves after STABLE_CYCLES consecutive
// sampled mismatches; any sample matching the current output abandons the
// attempt. upd is a combinational strobe that is high on the cycle whose
// closing edge loads a new output, so the parent can register a change pulse
// that lines up with the new output value.
module debounce_chan
   import fsm_pkg::*;
#(
   parameter int STABLE_CYCLES = 16,
   parameter int SYNC_STAGES   = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_raw,
   output logic d_out,
   output logic qual,
   output logic upd
);

   localparam int              CW       = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;
   db_state_e              r_state;
   logic [CW-1:0]          r_cnt;
   logic                   r_out;
   logic                   w_last;

   assign w_s = r_sync[SYNC_STAGES-1];

   // Synchroniser shift chain; the oldest flop is the clean sample.
   always_ff @(posedge clk) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], d_raw};
   end

   // Qualifier FSM: count consecutive mismatches, load the output on the last one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= DB_IDLE;
         r_cnt   <= '0;
         r_out   <= 1'b0;
      end else begin
         case (r_state)
            DB_IDLE: begin
               if (w_s != r_out) begin
                  if (STABLE_CYCLES == 1) begin
                     r_out <= w_s;
                  end else begin
                     r_state <= DB_QUAL;
                     r_cnt   <= CW'(1);
                  end
               end else begin
                  r_cnt <= '0;
               end
            end
            DB_QUAL: begin
               if (w_s == r_out) begin
                  r_state <= DB_IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_out   <= w_s;
                  r_cnt   <= '0;
                  r_state <= DB_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= DB_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Single-cycle qualification loads straight from IDLE; otherwise on the last QUAL count.
   assign w_last = (STABLE_CYCLES == 1) ? (r_state == DB_IDLE)
                                        : ((r_state == DB_QUAL) && (r_cnt == CNT_LAST));

   assign upd   = (w_s != r_out) && w_last;
   assign qual  = (r_state == DB_QUAL);
   assign d_out = r_out;

endmodule

// File: rtl/xz_input_conditioner.sv
// Conditions the raw x/z inputs for the 4-state Moore controller: each channel
// is synchronised and debounced independently, and a registered pulse marks
// the first cycle a new {x,z} pair is visible. Simultaneous updates on both
// channels produce a single pulse.
module xz_input_conditioner
   import fsm_pkg::*;
#(
   parameter int STABLE_CYCLES = 16,
   parameter int SYNC_STAGES   = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic x_raw,
   input  logic z_raw,
   output logic x,
   output logic z,
   output logic xz_changed,
   output logic busy
);

   logic w_x_qual;
   logic w_z_qual;
   logic w_x_upd;
   logic w_z_upd;
   logic r_changed;

   debounce_chan #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
   ) u_chan_x (
      .clk   (clk),
      .rst   (rst),
      .d_raw (x_raw),
      .d_out (x),
      .qual  (w_x_qual),
      .upd   (w_x_upd)
   );

   debounce_chan #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
   ) u_chan_z (
      .clk   (clk),
      .rst   (rst),
      .d_raw (z_raw),
      .d_out (z),
      .qual  (w_z_qual),
      .upd   (w_z_upd)
   );

   // Change pulse is loaded on the same edge as the channel outputs, so it coincides with the new pair.
   always_ff @(posedge clk) begin
      if (rst) r_changed <= 1'b0;
      else     r_changed <= w_x_upd | w_z_upd;
   end

   assign xz_changed = r_changed;
   assign busy       = w_x_qual | w_z_qual;

endmodule
